// File: rtl/intersection_ctrl.sv
// Two-approach signal scheduler: green/yellow/all-red sequencing, ped walk grants, emergency preempt.
// State and counters update one clock after inputs; lamps and walk decode from the registered state.
module intersection_ctrl #(
  parameter int GREEN_MIN = 256,
  parameter int GREEN_MAX = 1024,
  parameter int YELLOW    = 128,
  parameter int ALL_RED   = 32,
  parameter int WALK      = 64,
  parameter int CW        = 11
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       car_ns,
  input  logic       car_ew,
  input  logic       ped_ns,
  input  logic       ped_ew,
  input  logic       emg,
  input  logic       emg_dir,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic       walk_ns,
  output logic       walk_ew,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    NS_G  = 3'd0,
    NS_Y  = 3'd1,
    AR_EW = 3'd2,
    EW_G  = 3'd3,
    EW_Y  = 3'd4,
    AR_NS = 3'd5
  } state_e;

  localparam logic [CW-1:0] GMIN_LAST = CW'(GREEN_MIN - 1);
  localparam logic [CW-1:0] GMAX_LAST = CW'(GREEN_MAX - 1);
  localparam logic [CW-1:0] Y_LAST    = CW'(YELLOW - 1);
  localparam logic [CW-1:0] AR_LAST   = CW'(ALL_RED - 1);
  localparam logic [CW-1:0] WALK_LIM  = CW'(WALK);

  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_G = 3'b001;

  // Kept as a plain vector so codes 6/7 are representable and recoverable.
  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pend_ns_q, pend_ns_d;
  logic          pend_ew_q, pend_ew_d;
  logic          walk_act_ns_q, walk_act_ns_d;
  logic          walk_act_ew_q, walk_act_ew_d;

  logic cross_ns, cross_ew;
  logic ns_exit, ew_exit;
  logic in_green;
  logic enter_ns, enter_ew;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= NS_G;
      cnt_q         <= '0;
      pend_ns_q     <= 1'b0;
      pend_ew_q     <= 1'b0;
      walk_act_ns_q <= 1'b0;
      walk_act_ew_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      pend_ns_q     <= pend_ns_d;
      pend_ew_q     <= pend_ew_d;
      walk_act_ns_q <= walk_act_ns_d;
      walk_act_ew_q <= walk_act_ew_d;
    end
  end

  // Next state: a green in the preempt direction holds; the crossing green yields at once.
  always_comb begin
    state_d  = state_q;
    cross_ns = car_ew | pend_ew_q | ped_ew;
    cross_ew = car_ns | pend_ns_q | ped_ns;
    ns_exit  = cross_ns && ((cnt_q >= GMIN_LAST && !car_ns) || cnt_q >= GMAX_LAST);
    ew_exit  = cross_ew && ((cnt_q >= GMIN_LAST && !car_ew) || cnt_q >= GMAX_LAST);

    case (state_q)
      NS_G: begin
        if (emg) begin
          if (emg_dir) state_d = NS_Y;
        end else if (ns_exit) begin
          state_d = NS_Y;
        end
      end
      NS_Y: begin
        if (cnt_q == Y_LAST) state_d = AR_EW;
      end
      AR_EW: begin
        if (cnt_q == AR_LAST) state_d = (emg && !emg_dir) ? NS_G : EW_G;
      end
      EW_G: begin
        if (emg) begin
          if (!emg_dir) state_d = EW_Y;
        end else if (ew_exit) begin
          state_d = EW_Y;
        end
      end
      EW_Y: begin
        if (cnt_q == Y_LAST) state_d = AR_NS;
      end
      AR_NS: begin
        if (cnt_q == AR_LAST) state_d = (emg && emg_dir) ? EW_G : NS_G;
      end
      default: state_d = NS_G;
    endcase
  end

  // Interval counter restarts on every state change; greens saturate so GREEN_MAX stays reached.
  always_comb begin
    in_green = (state_q == NS_G) || (state_q == EW_G);
    cnt_d    = cnt_q + 1'b1;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (in_green && cnt_q == GMAX_LAST) begin
      cnt_d = cnt_q;
    end
  end

  // A green entered under preemption grants no walk and leaves the request pending.
  always_comb begin
    enter_ns      = (state_d == NS_G) && (state_q != NS_G);
    enter_ew      = (state_d == EW_G) && (state_q != EW_G);
    pend_ns_d     = pend_ns_q | ped_ns;
    pend_ew_d     = pend_ew_q | ped_ew;
    walk_act_ns_d = walk_act_ns_q;
    walk_act_ew_d = walk_act_ew_q;

    if (enter_ns) begin
      if (emg) begin
        walk_act_ns_d = 1'b0;
      end else begin
        walk_act_ns_d = pend_ns_q | ped_ns;
        pend_ns_d     = 1'b0;
      end
    end

    if (enter_ew) begin
      if (emg) begin
        walk_act_ew_d = 1'b0;
      end else begin
        walk_act_ew_d = pend_ew_q | ped_ew;
        pend_ew_d     = 1'b0;
      end
    end
  end

  always_comb begin
    ns_light = LAMP_R;
    ew_light = LAMP_R;
    case (state_q)
      NS_G:    ns_light = LAMP_G;
      NS_Y:    ns_light = LAMP_Y;
      EW_G:    ew_light = LAMP_G;
      EW_Y:    ew_light = LAMP_Y;
      default: begin
        ns_light = LAMP_R;
        ew_light = LAMP_R;
      end
    endcase

    walk_ns = walk_act_ns_q && (state_q == NS_G) && (cnt_q < WALK_LIM) && !emg;
    walk_ew = walk_act_ew_q && (state_q == EW_G) && (cnt_q < WALK_LIM) && !emg;
    state_o = state_q;
  end

endmodule

// File: tb/tb_intersection_ctrl.sv
// Directed checks of intersection_ctrl with short timing parameters, plus a random safety soak.
module tb_intersection_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       car_ns = 1'b0, car_ew = 1'b0, ped_ns = 1'b0, ped_ew = 1'b0;
  logic       emg = 1'b0, emg_dir = 1'b0;
  logic [2:0] ns_light, ew_light, state_o;
  logic       walk_ns, walk_ew;

  int n_chk  = 0;
  int n_pass = 0;
  int viol   = 0;

  intersection_ctrl #(
    .GREEN_MIN(8), .GREEN_MAX(16), .YELLOW(4), .ALL_RED(2), .WALK(3), .CW(5)
  ) dut (
    .clk(clk), .rst(rst),
    .car_ns(car_ns), .car_ew(car_ew), .ped_ns(ped_ns), .ped_ew(ped_ew),
    .emg(emg), .emg_dir(emg_dir),
    .ns_light(ns_light), .ew_light(ew_light),
    .walk_ns(walk_ns), .walk_ew(walk_ew), .state_o(state_o)
  );

  always #5 clk = ~clk;

  // Continuous lamp safety monitor over the whole run.
  always @(negedge clk) begin
    if (!$onehot(ns_light) || !$onehot(ew_light) ||
        (ns_light != 3'b100 && ew_light != 3'b100))
      viol++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Leaves the bench at the negedge that opens cycle 0 (NS_G, cnt=0).
  task automatic reset_dut();
    rst = 1'b1;
    {car_ns, car_ew, ped_ns, ped_ew, emg, emg_dir} = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int exp_st;

    // Reset state
    reset_dut();
    #1;
    chk("rst_state", state_o, 0);
    chk("rst_ns", ns_light, 3'b001);
    chk("rst_ew", ew_light, 3'b100);
    chk("rst_walk", {walk_ns, walk_ew}, 0);

    // Cross traffic only: min green then yellow, all-red, EW green
    reset_dut();
    for (int c = 0; c <= 15; c++) begin
      if (c > 0) @(negedge clk);
      car_ew = 1'b1;
      #1;
      exp_st = (c < 8) ? 0 : (c < 12) ? 1 : (c < 14) ? 2 : 3;
      chk("t1_state", state_o, exp_st);
      if (c == 8)  chk("t1_ns_y", ns_light, 3'b010);
      if (c == 12) chk("t1_ar", {ns_light, ew_light}, 6'b100100);
      if (c == 14) chk("t1_ew_g", ew_light, 3'b001);
    end

    // Both approaches busy: green runs to max
    reset_dut();
    for (int c = 0; c <= 16; c++) begin
      if (c > 0) @(negedge clk);
      car_ns = 1'b1;
      car_ew = 1'b1;
      #1;
      chk("t2_max", state_o, (c < 16) ? 0 : 1);
    end

    // No cross demand: green rests
    reset_dut();
    car_ns = 1'b1;
    repeat (120) @(negedge clk);
    #1;
    chk("t2_rest_state", state_o, 0);
    chk("t2_rest_lamps", {ns_light, ew_light}, 6'b001100);

    // Ped request in EW green drives min-green exit, then 3-cycle NS walk
    reset_dut();
    for (int c = 0; c <= 31; c++) begin
      if (c > 0) @(negedge clk);
      car_ew = (c < 14);
      ped_ns = (c == 16);
      #1;
      exp_st = (c < 8) ? 0 : (c < 12) ? 1 : (c < 14) ? 2 : (c < 22) ? 3 :
               (c < 26) ? 4 : (c < 28) ? 5 : 0;
      chk("t3_state", state_o, exp_st);
      chk("t3_walk_ns", walk_ns, (c >= 28 && c <= 30) ? 1 : 0);
    end
    chk("t3_pend_clear", dut.pend_ns_q, 0);

    // Emergency to EW: NS cut short, EW held, resume, then walk suppressed by preempt
    reset_dut();
    for (int c = 0; c <= 71; c++) begin
      if (c > 0) @(negedge clk);
      car_ns  = 1'b1;
      car_ew  = 1'b0;
      emg     = (c >= 1 && c < 40) || (c >= 70);
      emg_dir = 1'b1;
      ped_ew  = (c == 3);
      #1;
      exp_st = (c < 2) ? 0 : (c < 6) ? 1 : (c < 8) ? 2 : (c < 41) ? 3 :
               (c < 45) ? 4 : (c < 47) ? 5 : (c < 63) ? 0 : (c < 67) ? 1 :
               (c < 69) ? 2 : 3;
      chk("t4_state", state_o, exp_st);
      chk("t4_walk_ew", walk_ew, (c == 69) ? 1 : 0);
    end

    // Reset during EW yellow
    reset_dut();
    for (int c = 0; c <= 24; c++) begin
      if (c > 0) @(negedge clk);
      car_ew = (c < 14);
      car_ns = (c >= 14);
      emg    = 1'b0;
      rst    = (c == 23);
      #1;
      exp_st = (c < 8) ? 0 : (c < 12) ? 1 : (c < 14) ? 2 : (c < 22) ? 3 :
               (c < 24) ? 4 : 0;
      chk("t5_state", state_o, exp_st);
    end
    chk("t5_lamps", {ns_light, ew_light}, 6'b001100);
    chk("t5_walk", {walk_ns, walk_ew}, 0);

    // Illegal state recovery
    @(negedge clk);
    force dut.state_q = 3'd6;
    #1;
    release dut.state_q;
    chk("ill_forced", state_o, 6);
    @(negedge clk);
    #1;
    chk("ill_recover", state_o, 0);

    // Random soak; lamp safety is tracked by the monitor
    reset_dut();
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 15) == 0) car_ns = ~car_ns;
      if ($urandom_range(0, 15) == 0) car_ew = ~car_ew;
      ped_ns = ($urandom_range(0, 63) == 0);
      ped_ew = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 99) == 0) emg = ~emg;
      if ($urandom_range(0, 49) == 0) emg_dir = ~emg_dir;
    end
    @(negedge clk);
    chk("safety_viol", viol, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
